uart_tx: RTL and testbench

Serial UART transmitter, 8N1 framing, LSB first. It is the transmit counterpart of uart_rx and shares its clock and bit timing (125 MHz clk, 115200 baud).
- Bytes are accepted over a valid/ready handshake into a small FIFO.
- Bytes are serialized back-to-back onto tx_out.
- The block sits between the RPN result path and the board TX pin.

---
 rtl/uart_tx.sv | 136 +++++++++++++
 tb/tb_uart_tx.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first, fed by a small byte FIFO over a valid/ready handshake.
// Frames are sent back-to-back whenever the FIFO still holds data at the end of a stop bit.
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 1085,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_in,
  input  logic       valid,
  output logic       ready,
  output logic       tx_out,
  output logic       busy
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);
  localparam logic [PtrW:0]   Depth  = (PtrW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]   count_q, count_d;
  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            fifo_full, fifo_empty, push, pop, wrap;

  assign fifo_full  = (count_q == Depth);
  assign fifo_empty = (count_q == '0);
  assign ready      = !fifo_full;
  assign push       = valid && ready;
  assign wrap       = (cnt_q == CntMax);
  assign tx_out     = tx_q;
  assign busy       = (state_q != StIdle) || !fifo_empty;

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = wrap ? '0 : cnt_q + 1'b1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    pop       = 1'b0;
    unique case (state_q)
      StIdle: begin
        tx_d  = 1'b1;
        cnt_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          tx_d    = 1'b0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (wrap) begin
          tx_d      = shift_q[0];
          bit_idx_d = '0;
          state_d   = StData;
        end
      end
      StData: begin
        if (wrap) begin
          if (bit_idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = StStop;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
          end
        end
      end
      StStop: begin
        if (wrap) begin
          // A byte pushed on this very edge is not visible yet; it starts from idle.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            tx_d    = 1'b0;
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a frame-level model (byte queue plus position within a 10-bit frame)
// predicts tx_out/busy/ready every cycle; directed scenarios add literal expectations.
module tb_uart_tx;

  localparam int unsigned Cpb     = 16;
  localparam int unsigned Depth   = 4;
  localparam int unsigned SlowCpb = 1085;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data_in = '0;
  logic       valid = 1'b0;
  logic       ready, tx_out, busy;
  logic [7:0] data_s = '0;
  logic       valid_s = 1'b0;
  logic       ready_s, tx_s, busy_s;

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(Cpb), .FIFO_DEPTH(Depth)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .data_in(data_in),
    .valid  (valid),
    .ready  (ready),
    .tx_out (tx_out),
    .busy   (busy)
  );

  uart_tx #(.CLKS_PER_BIT(SlowCpb), .FIFO_DEPTH(Depth)) dut_slow (
    .clk    (clk),
    .rst_n  (rst_n),
    .data_in(data_s),
    .valid  (valid_s),
    .ready  (ready_s),
    .tx_out (tx_s),
    .busy   (busy_s)
  );

  int tests = 0;
  int fails = 0;

  // Model: pending bytes, frame in flight and cycle position within it.
  logic [7:0] mq[$];
  logic [7:0] sent[$];
  bit         active = 1'b0;
  int         t = 0;
  logic [7:0] cur = '0;
  logic       exp_tx = 1'b1, exp_busy = 1'b0, exp_ready = 1'b1;
  bit         chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    check(name, 32'(act), 32'(exp));
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i == 9) return 1'b1;
    return b[i-1];
  endfunction

  task automatic exp_update();
    exp_tx    = active ? frame_bit(cur, t / Cpb) : 1'b1;
    exp_busy  = active || (mq.size() != 0);
    exp_ready = mq.size() < Depth;
  endtask

  task automatic model_clear();
    mq.delete();
    active = 1'b0;
    t      = 0;
    exp_update();
  endtask

  // Called just after each rising edge with the inputs that edge saw.
  task automatic model_update();
    bit pre_nonempty, do_push, can_start;
    pre_nonempty = (mq.size() != 0);
    do_push      = valid && (mq.size() < Depth);
    if (!rst_n) begin
      model_clear();
      return;
    end
    can_start = !active || (t == 10 * Cpb - 1);
    if (active) t++;
    if (can_start) begin
      if (pre_nonempty) begin
        cur = mq.pop_front();
        sent.push_back(cur);
        active = 1'b1;
        t = 0;
      end else begin
        active = 1'b0;
      end
    end
    if (do_push) mq.push_back(data_in);
    exp_update();
  endtask

  task automatic drive(input logic v, input logic [7:0] d);
    valid   = v;
    data_in = d;
    @(posedge clk);
    model_update();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || exp_busy) && n < 3000) begin
      drive(1'b0, 8'h00);
      n++;
    end
    chk1("drain to idle", busy, 1'b0);
  endtask

  always @(negedge clk) begin
    if (chk_en) check("cycle {tx,busy,ready}", 32'({tx_out, busy, ready}),
                      32'({exp_tx, exp_busy, exp_ready}));
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    int n, cyc, s0;
    logic [9:0] seq;
    model_clear();
    chk_en = 1'b1;

    // Reset and idle.
    repeat (5) drive(1'b0, 8'h00);
    chk1("reset tx", tx_out, 1'b1);
    chk1("reset busy", busy, 1'b0);
    chk1("reset ready", ready, 1'b1);
    rst_n = 1'b1;
    repeat (100) drive(1'b0, 8'h00);
    chk1("idle tx", tx_out, 1'b1);

    // Random traffic with occasional backpressure.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 99) < 8, 8'($urandom));
    end
    wait_idle();

    // Back-to-back frames.
    drive(1'b1, 8'hA5);
    drive(1'b1, 8'h3C);
    chk1("b2b start bit", tx_out, 1'b0);
    n = 0;
    while (busy && n < 1000) begin
      n++;
      drive(1'b0, 8'h00);
    end
    check("b2b busy cycles from first start", 32'(n), 32'd320);
    check("b2b first byte", 32'(sent[$-1]), 32'h A5);
    check("b2b second byte", 32'(sent[$]), 32'h 3C);

    // Backpressure: upstream holds each byte until accepted.
    s0 = sent.size();
    n = 1;
    while (ready && n < 20) begin
      drive(1'b1, 8'(n));
      n++;
    end
    check("bytes accepted before full", 32'(n - 1), 32'd5);
    chk1("ready low when full", ready, 1'b0);
    repeat (20) drive(1'b1, 8'h06);
    wait_idle();
    check("backpressure frame count", 32'(sent.size() - s0), 32'd5);
    for (int k = 0; k < 5; k++) check("backpressure byte order", 32'(sent[s0 + k]), 32'(k + 1));

    // Asynchronous reset during data bit 3 with a second byte queued.
    drive(1'b1, 8'hC3);
    drive(1'b1, 8'h9A);
    repeat (4 * Cpb + 5) drive(1'b0, 8'h00);
    chk1("data bit 3 of 0xC3", tx_out, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk1("async reset tx", tx_out, 1'b1);
    chk1("async reset busy", busy, 1'b0);
    chk1("async reset ready", ready, 1'b1);
    model_clear();
    repeat (3) drive(1'b0, 8'h00);
    rst_n = 1'b1;
    drive(1'b1, 8'h55);
    wait_idle();
    check("post-reset byte", 32'(sent[$]), 32'h55);

    // Push coinciding with the stop-bit wrap on an empty FIFO.
    drive(1'b1, 8'h8E);
    drive(1'b0, 8'h00);
    chk1("stop-wrap frame start", tx_out, 1'b0);
    repeat (159) drive(1'b0, 8'h00);
    chk1("stop bit", tx_out, 1'b1);
    drive(1'b1, 8'h6B);
    chk1("gap cycle high", tx_out, 1'b1);
    chk1("gap cycle busy", busy, 1'b1);
    drive(1'b0, 8'h00);
    chk1("start after gap", tx_out, 1'b0);
    wait_idle();
    check("stop-wrap byte", 32'(sent[$]), 32'h6B);

    // Full-rate single byte 0x30 on the 1085-cycle instance.
    valid_s = 1'b1;
    data_s  = 8'h30;
    drive(1'b0, 8'h00);
    valid_s = 1'b0;
    chk1("slow tx before start", tx_s, 1'b1);
    chk1("slow busy after accept", busy_s, 1'b1);
    drive(1'b0, 8'h00);
    chk1("slow start fall", tx_s, 1'b0);
    seq = 10'b10_0110_0000;
    cyc = 0;
    for (int k = 0; k < 10; k++) begin
      while (cyc < k * int'(SlowCpb) + 542) begin
        drive(1'b0, 8'h00);
        cyc++;
      end
      chk1("slow mid-bit value", tx_s, seq[k]);
    end
    while (cyc < 10 * int'(SlowCpb) - 1) begin
      drive(1'b0, 8'h00);
      cyc++;
    end
    chk1("slow busy last cycle", busy_s, 1'b1);
    drive(1'b0, 8'h00);
    chk1("slow busy drop", busy_s, 1'b0);
    chk1("slow tx idle", tx_s, 1'b1);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
